// File: rtl/tile_scroller.sv
// Scrolling tilemap renderer between VGA counters and pins: 5-cycle fixed latency, syncs delayed to match.
// No backpressure: one pixel per VGA_CLK, the write port is always accepted.
module tile_scroller #(
  parameter int TILE_BITS     = 5,
  parameter int MAP_COLS_BITS = 6,
  parameter int MAP_ROWS_BITS = 4,
  parameter int TILE_IDX_BITS = 8,
  parameter int COLOR_BITS    = 4,
  localparam int WX = MAP_COLS_BITS + TILE_BITS,
  localparam int WY = MAP_ROWS_BITS + TILE_BITS,
  localparam int WA = (TILE_IDX_BITS + 2*TILE_BITS > MAP_ROWS_BITS + MAP_COLS_BITS) ?
                      (TILE_IDX_BITS + 2*TILE_BITS) : (MAP_ROWS_BITS + MAP_COLS_BITS)
) (
  input  logic          VGA_CLK,
  input  logic          VGA_RESET_n,
  input  logic [9:0]    px_x,
  input  logic [8:0]    px_y,
  input  logic          blank_n_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          wr_en,
  input  logic [1:0]    wr_sel,
  input  logic [WA-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_n,
  output logic          frame_commit
);

  localparam int MAP_AW = MAP_ROWS_BITS + MAP_COLS_BITS;
  localparam int SET_AW = TILE_IDX_BITS + 2*TILE_BITS;

  logic [WX-1:0] scroll_x_pend, scroll_x_act;
  logic [WY-1:0] scroll_y_pend, scroll_y_act;
  logic [23:0]   bg_color;
  logic          bg_en;
  logic          vs_q;
  logic          vs_fall;
  logic          ctrl_wr;

  logic [TILE_IDX_BITS-1:0] tilemap [2**MAP_AW];
  logic [COLOR_BITS-1:0]    tileset [2**SET_AW];
  logic [23:0]              palette [2**COLOR_BITS];

  logic [WX-1:0]            wx_q;
  logic [WY-1:0]            wy_q;
  logic [TILE_IDX_BITS-1:0] tile_q;
  logic [TILE_BITS-1:0]     fx_q, fy_q;
  logic [COLOR_BITS-1:0]    cidx_q, cidx4_q;
  logic [23:0]              pal_q;
  logic [23:0]              rgb_q;
  logic [4:0]               hs_sr, vs_sr, bl_sr;

  assign vs_fall = vs_q && !vs_in;
  assign ctrl_wr = wr_en && (wr_sel == 2'd3);

  // Active scroll only changes one cycle after the vsync falling edge, so a whole frame uses one offset.
  always_ff @(posedge VGA_CLK or negedge VGA_RESET_n) begin
    if (!VGA_RESET_n) begin
      scroll_x_pend <= '0;
      scroll_y_pend <= '0;
      scroll_x_act  <= '0;
      scroll_y_act  <= '0;
      bg_color      <= '0;
      bg_en         <= 1'b0;
      vs_q          <= 1'b0;
      frame_commit  <= 1'b0;
    end else begin
      vs_q         <= vs_in;
      frame_commit <= vs_fall;
      if (vs_fall) begin
        scroll_x_act <= scroll_x_pend;
        scroll_y_act <= scroll_y_pend;
      end
      if (ctrl_wr) begin
        case (wr_addr[1:0])
          2'd0:    scroll_x_pend <= wr_data[WX-1:0];
          2'd1:    scroll_y_pend <= wr_data[WY-1:0];
          2'd2:    bg_color      <= wr_data;
          default: bg_en         <= wr_data[0];
        endcase
      end
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (wr_en) begin
      case (wr_sel)
        2'd0:    tilemap[wr_addr[MAP_AW-1:0]]     <= wr_data[TILE_IDX_BITS-1:0];
        2'd1:    tileset[wr_addr[SET_AW-1:0]]     <= wr_data[COLOR_BITS-1:0];
        2'd2:    palette[wr_addr[COLOR_BITS-1:0]] <= wr_data;
        default: ;
      endcase
    end
  end

  // Sum width equals world width, so carries drop and the map wraps toroidally.
  always_ff @(posedge VGA_CLK or negedge VGA_RESET_n) begin
    if (!VGA_RESET_n) begin
      wx_q    <= '0;
      wy_q    <= '0;
      tile_q  <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      cidx_q  <= '0;
      cidx4_q <= '0;
      pal_q   <= '0;
      rgb_q   <= '0;
      hs_sr   <= '1;
      vs_sr   <= '1;
      bl_sr   <= '0;
    end else begin
      wx_q    <= WX'(px_x) + scroll_x_act;
      wy_q    <= WY'(px_y) + scroll_y_act;
      tile_q  <= tilemap[{wy_q[WY-1:TILE_BITS], wx_q[WX-1:TILE_BITS]}];
      fx_q    <= wx_q[TILE_BITS-1:0];
      fy_q    <= wy_q[TILE_BITS-1:0];
      cidx_q  <= tileset[{tile_q, fy_q, fx_q}];
      pal_q   <= palette[cidx_q];
      cidx4_q <= cidx_q;
      hs_sr   <= {hs_sr[3:0], hs_in};
      vs_sr   <= {vs_sr[3:0], vs_in};
      bl_sr   <= {bl_sr[3:0], blank_n_in};
      if (!bl_sr[3])
        rgb_q <= '0;
      else if (cidx4_q == '0 && bg_en)
        rgb_q <= bg_color;
      else
        rgb_q <= pal_q;
    end
  end

  assign VGA_R       = rgb_q[7:0];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[23:16];
  assign VGA_HS      = hs_sr[4];
  assign VGA_VS      = vs_sr[4];
  assign VGA_BLANK_n = bl_sr[4];

endmodule

// File: tb/tb_tile_scroller.sv
// Directed bench for tile_scroller: reset, latency, wrap, scroll commit, transparency, blanking/sync alignment.
module tb_tile_scroller;

  logic        VGA_CLK = 1'b0;
  logic        VGA_RESET_n = 1'b1;
  logic [9:0]  px_x = '0;
  logic [8:0]  px_y = '0;
  logic        blank_n_in = 1'b0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_sel = '0;
  logic [17:0] wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_n, frame_commit;
  logic [23:0] rgb;

  int vectors = 0;
  int miscompares = 0;

  assign rgb = {VGA_B, VGA_G, VGA_R};

  always #5 VGA_CLK = ~VGA_CLK;

  tile_scroller dut (
    .VGA_CLK(VGA_CLK), .VGA_RESET_n(VGA_RESET_n),
    .px_x(px_x), .px_y(px_y), .blank_n_in(blank_n_in), .hs_in(hs_in), .vs_in(vs_in),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
    .frame_commit(frame_commit)
  );

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [17:0] addr, input logic [23:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic vsync();
    vs_in = 1'b0;
    repeat (2) tick();
    vs_in = 1'b1;
    tick();
  endtask

  task automatic drive_pixel(input logic [9:0] x, input logic [8:0] y);
    px_x = x; px_y = y; blank_n_in = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    #2 VGA_RESET_n = 1'b0;
    #1;
    vectors++;
    if ({rgb, VGA_HS, VGA_VS, VGA_BLANK_n, frame_commit} !== {24'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_hold got rgb=%h hs=%b vs=%b bl=%b fc=%b exp rgb=0 hs=1 vs=1 bl=0 fc=0",
               rgb, VGA_HS, VGA_VS, VGA_BLANK_n, frame_commit);
    end
    hs_in = 1'b0; vs_in = 1'b0; blank_n_in = 1'b1;
    repeat (3) tick();
    VGA_RESET_n = 1'b1;
    repeat (4) tick();
    vectors++;
    if ({VGA_HS, VGA_VS, VGA_BLANK_n, rgb} !== {1'b1, 1'b1, 1'b0, 24'h0}) begin
      miscompares++;
      $display("FAIL reset_fill4 got hs=%b vs=%b bl=%b rgb=%h exp hs=1 vs=1 bl=0 rgb=0",
               VGA_HS, VGA_VS, VGA_BLANK_n, rgb);
    end
    tick();
    vectors++;
    if ({VGA_HS, VGA_VS, VGA_BLANK_n} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_fill5 got hs=%b vs=%b bl=%b exp hs=0 vs=0 bl=1", VGA_HS, VGA_VS, VGA_BLANK_n);
    end
    @(posedge VGA_CLK);
    #3 VGA_RESET_n = 1'b0;
    #1;
    vectors++;
    if ({rgb, VGA_HS, VGA_VS, VGA_BLANK_n, frame_commit} !== {24'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async got rgb=%h hs=%b vs=%b bl=%b fc=%b exp rgb=0 hs=1 vs=1 bl=0 fc=0",
               rgb, VGA_HS, VGA_VS, VGA_BLANK_n, frame_commit);
    end
    hs_in = 1'b1; vs_in = 1'b1; blank_n_in = 1'b0;
    repeat (2) tick();
    VGA_RESET_n = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_latency();
    wr(2'd0, 18'd0, 24'd1);
    wr(2'd1, 18'd1024, 24'd3);
    wr(2'd2, 18'd3, 24'h112233);
    blank_n_in = 1'b0;
    repeat (5) tick();
    px_x = 10'd0; px_y = 9'd0; blank_n_in = 1'b1;
    repeat (4) tick();
    vectors++;
    if ({rgb, VGA_BLANK_n} !== {24'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL lat_n4 got rgb=%h bl=%b exp rgb=000000 bl=0", rgb, VGA_BLANK_n);
    end
    tick();
    vectors++;
    if ({rgb, VGA_BLANK_n} !== {24'h112233, 1'b1}) begin
      miscompares++;
      $display("FAIL lat_n5 got rgb=%h bl=%b exp rgb=112233 bl=1", rgb, VGA_BLANK_n);
    end
    blank_n_in = 1'b0;
  endtask

  task automatic test_wrap();
    wr(2'd1, 18'd1026, 24'd5);
    wr(2'd2, 18'd5, 24'h445566);
    wr(2'd0, 18'd63, 24'd2);
    wr(2'd1, 18'd2079, 24'd6);
    wr(2'd2, 18'd6, 24'h778899);
    wr(2'd3, 18'd0, 24'd2040);
    vsync();
    drive_pixel(10'd10, 9'd0);
    vectors++;
    if (rgb !== 24'h445566) begin
      miscompares++;
      $display("FAIL wrap_x10 got %h exp 445566", rgb);
    end
    drive_pixel(10'd7, 9'd0);
    vectors++;
    if (rgb !== 24'h778899) begin
      miscompares++;
      $display("FAIL wrap_x7 got %h exp 778899", rgb);
    end
  endtask

  task automatic test_commit();
    wr(2'd0, 18'd1, 24'd3);
    wr(2'd1, 18'd3072, 24'd7);
    wr(2'd2, 18'd7, 24'hAABBCC);
    wr(2'd0, 18'd2, 24'd4);
    wr(2'd1, 18'd4096, 24'd8);
    wr(2'd2, 18'd8, 24'h010203);
    wr(2'd3, 18'd0, 24'd0);
    vsync();
    drive_pixel(10'd0, 9'd0);
    vectors++;
    if (rgb !== 24'h112233) begin
      miscompares++;
      $display("FAIL commit_base got %h exp 112233", rgb);
    end
    wr(2'd3, 18'd0, 24'd32);
    drive_pixel(10'd0, 9'd0);
    vectors++;
    if (rgb !== 24'h112233) begin
      miscompares++;
      $display("FAIL commit_pending got %h exp 112233", rgb);
    end
    vs_in = 1'b0;
    vectors++;
    if (frame_commit !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_pulse_e got %b exp 0", frame_commit);
    end
    tick();
    vectors++;
    if (frame_commit !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_pulse_e1 got %b exp 1", frame_commit);
    end
    tick();
    vectors++;
    if (frame_commit !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_pulse_e2 got %b exp 0", frame_commit);
    end
    vs_in = 1'b1;
    tick();
    drive_pixel(10'd0, 9'd0);
    vectors++;
    if (rgb !== 24'hAABBCC) begin
      miscompares++;
      $display("FAIL commit_applied got %h exp aabbcc", rgb);
    end
    // Pend write lands on the same edge that commits: the old pend (32) must win.
    vs_in = 1'b0;
    wr(2'd3, 18'd0, 24'd64);
    tick();
    vs_in = 1'b1;
    tick();
    drive_pixel(10'd0, 9'd0);
    vectors++;
    if (rgb !== 24'hAABBCC) begin
      miscompares++;
      $display("FAIL commit_same_cycle got %h exp aabbcc", rgb);
    end
    vsync();
    drive_pixel(10'd0, 9'd0);
    vectors++;
    if (rgb !== 24'h010203) begin
      miscompares++;
      $display("FAIL commit_next_frame got %h exp 010203", rgb);
    end
  endtask

  task automatic test_transparency();
    wr(2'd3, 18'd0, 24'd0);
    vsync();
    wr(2'd1, 18'd1025, 24'd0);
    wr(2'd2, 18'd0, 24'h00AA00);
    wr(2'd3, 18'd2, 24'h0000FF);
    wr(2'd3, 18'd3, 24'd1);
    drive_pixel(10'd1, 9'd0);
    vectors++;
    if (rgb !== 24'h0000FF) begin
      miscompares++;
      $display("FAIL transp_bg got %h exp 0000ff", rgb);
    end
    drive_pixel(10'd0, 9'd0);
    vectors++;
    if (rgb !== 24'h112233) begin
      miscompares++;
      $display("FAIL transp_opaque got %h exp 112233", rgb);
    end
    wr(2'd3, 18'd3, 24'd0);
    drive_pixel(10'd1, 9'd0);
    vectors++;
    if (rgb !== 24'h00AA00) begin
      miscompares++;
      $display("FAIL transp_off got %h exp 00aa00", rgb);
    end
  endtask

  task automatic test_blanking();
    drive_pixel(10'd0, 9'd0);
    blank_n_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    repeat (4) tick();
    vectors++;
    if ({rgb, VGA_BLANK_n, VGA_HS, VGA_VS} !== {24'h112233, 3'b111}) begin
      miscompares++;
      $display("FAIL blank_n4 got rgb=%h bl=%b hs=%b vs=%b exp rgb=112233 bl=1 hs=1 vs=1",
               rgb, VGA_BLANK_n, VGA_HS, VGA_VS);
    end
    tick();
    vectors++;
    if ({rgb, VGA_BLANK_n, VGA_HS, VGA_VS} !== {24'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL blank_n5 got rgb=%h bl=%b hs=%b vs=%b exp rgb=000000 bl=0 hs=0 vs=0",
               rgb, VGA_BLANK_n, VGA_HS, VGA_VS);
    end
    hs_in = 1'b1; vs_in = 1'b1;
    repeat (4) tick();
    vectors++;
    if ({VGA_HS, VGA_VS} !== 2'b00) begin
      miscompares++;
      $display("FAIL sync_rise4 got hs=%b vs=%b exp hs=0 vs=0", VGA_HS, VGA_VS);
    end
    tick();
    vectors++;
    if ({VGA_HS, VGA_VS} !== 2'b11) begin
      miscompares++;
      $display("FAIL sync_rise5 got hs=%b vs=%b exp hs=1 vs=1", VGA_HS, VGA_VS);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wrap();
    test_commit();
    test_transparency();
    test_blanking();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
